// File: rtl/byte_sched_pkg.sv
// byte_sched_pkg: shared widths, FSM state type and byte-select helper
// for the byte_sched word-to-byte serializer.
package byte_sched_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 64;
    localparam int BYTES_PER_WORD = 8;
    localparam int IDX_W          = 3;

    // Index of the final byte of a word; its handshake ends the transfer.
    localparam logic [IDX_W-1:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } sched_state_t;

    // Byte idx of a word, byte 0 being the least significant.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                    input logic [IDX_W-1:0]  idx);
        word_byte = word[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/byte_sched_rr_arb.sv
// byte_sched_rr_arb: combinational rotating-priority arbiter. Grants the
// first set request at or above the pointer, otherwise wraps to the lowest
// set request. Holds no state; the pointer is owned by the caller.
module byte_sched_rr_arb #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_ID_W-1:0] pointer,
    output logic                any_grant,
    output logic [REQ_ID_W-1:0] grant_idx
);

    logic                w_hi_found;
    logic [REQ_ID_W-1:0] w_hi_idx;
    logic                w_lo_found;
    logic [REQ_ID_W-1:0] w_lo_idx;

    // Two priority scans: lowest request overall, and lowest at/after pointer.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[k] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = REQ_ID_W'(k);
            end
            if (req[k] && !w_hi_found && (REQ_ID_W'(k) >= pointer)) begin
                w_hi_found = 1'b1;
                w_hi_idx   = REQ_ID_W'(k);
            end
        end
        any_grant = w_lo_found;
        grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

endmodule

// File: rtl/byte_sched.sv
// byte_sched: round-robin shares one 64-bit word serializer between
// NUM_REQ requesters. The winner's word leaves LSB byte first on a
// valid/ready byte stream, then the winner gets a one-cycle req_ack.
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high; once raised, byte_valid and byte_out stay
// stable until that transfer, and byte_valid never drops inside a word.
// Optional macro BYTE_SCHED_LAST_EN adds byte_last, which flags the
// final byte of each word.
module byte_sched
    import byte_sched_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int REQ_ID_W = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [BYTE_W-1:0]         byte_out,
    output logic                      byte_valid,
    input  logic                      byte_ready,
    output logic                      busy,
`ifdef BYTE_SCHED_LAST_EN
    output logic                      byte_last,
`endif
    output logic [REQ_ID_W-1:0]       grant_id
);

    sched_state_t        r_state;
    sched_state_t        w_next_state;
    logic [REQ_ID_W-1:0] r_ptr;
    logic [REQ_ID_W-1:0] r_grant_id;
    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_word;
    logic [BYTE_W-1:0]   r_byte_out;
    logic                r_byte_valid;

    logic                w_any_grant;
    logic [REQ_ID_W-1:0] w_grant_idx;
    logic [WORD_W-1:0]   w_win_word;
    logic                w_hs;
    logic                w_last_hs;

    byte_sched_rr_arb #(
        .NUM_REQ  (NUM_REQ),
        .REQ_ID_W (REQ_ID_W)
    ) u_arb (
        .req       (req),
        .pointer   (r_ptr),
        .any_grant (w_any_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_hs      = r_byte_valid & byte_ready;
    assign w_last_hs = w_hs && (r_idx == LAST_IDX);

    // Select the winning requester's word from the flat req_data bus.
    always_comb begin
        w_win_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_idx == REQ_ID_W'(k)) begin
                w_win_word = req_data[k*WORD_W +: WORD_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and state-decoded outputs (busy, one-hot ack in ACK).
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        req_ack      = '0;
        case (r_state)
            IDLE: begin
                if (w_any_grant) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (w_last_hs) begin
                    w_next_state = ACK;
                end
            end
            ACK: begin
                busy = 1'b1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    req_ack[k] = (r_grant_id == REQ_ID_W'(k));
                end
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch the winner on grant, step through bytes on handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_grant_id   <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_grant) begin
                        r_word       <= w_win_word;
                        r_byte_out   <= word_byte(w_win_word, '0);
                        r_byte_valid <= 1'b1;
                        r_idx        <= '0;
                        r_grant_id   <= w_grant_idx;
                        r_ptr        <= (w_grant_idx == REQ_ID_W'(NUM_REQ - 1)) ?
                                        '0 : w_grant_idx + 1'b1;
                    end
                end
                SEND: begin
                    if (w_last_hs) begin
                        r_byte_valid <= 1'b0;
                        r_byte_out   <= '0;
                        r_idx        <= '0;
                    end else if (w_hs) begin
                        r_idx      <= r_idx + 3'd1;
                        r_byte_out <= word_byte(r_word, r_idx + 3'd1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign grant_id   = r_grant_id;

`ifdef BYTE_SCHED_LAST_EN
    assign byte_last = r_byte_valid && (r_idx == LAST_IDX);
`endif

endmodule
